ps2_keyboard: RTL and testbench
===============================

Name: ps2_keyboard

Overview:
- Upstream feeder for the memory map's keyboard register (address 0x6000).
- Deserializes PS/2 scan-code set 2 frames from a physical keyboard and translates make/break codes into a Hack key code.
- Holds that code on out while the key is down, and drives 0 when no key is pressed.
- Its out drives the keyboard word read by the data memory.

Parameters:
TIMEOUT, 5000, clock cycles without a PS/2 falling edge inside a frame before the receiver abandons it (counter width ceil(log2(TIMEOUT+1))).

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
ps2_clk  input  1  raw PS/2 clock, asynchronous
ps2_data  input  1  raw PS/2 data, asynchronous
out  output  16  current Hack key code, 0 = no key
key_valid  output  1  one-cycle pulse when out takes a new nonzero value
frame_err  output  1  one-cycle pulse on parity or stop-bit error

Behaviour:
- Reset:
  - out=0, key_valid=0, frame_err=0.
  - State IDLE, bit count 0, ext/brk flags 0, timeout counter 0.
  - Synchronizer flops reset to 1.
  - Reset mid-frame discards the partial byte.
- Input capture:
  - ps2_clk and ps2_data each pass through two flops.
  - A falling edge is detected when the previous synced clk is 1 and the current synced clk is 0.
  - Data is sampled from synced ps2_data in that same cycle.
- Frame format: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1).
- FSM:
  - IDLE: on a falling edge with data=0, go to RECV with count=1. A falling edge with data=1 is ignored.
  - RECV: shift one bit per falling edge.
    - After the 11th bit, go to CHECK.
    - The timeout counter clears on every falling edge. When it reaches TIMEOUT, go to IDLE silently, with no frame_err.
  - CHECK (1 cycle):
    - Good if the XOR of d0..d7 and parity is 1 and stop=1. Good goes to DECODE.
    - Otherwise pulse frame_err, clear ext/brk, and go to IDLE.
  - DECODE (1 cycle): apply the byte, then go to IDLE.
    - Timing: out and key_valid register on the edge ending DECODE. That is 2 clocks after the stop-bit detect cycle.
- Decode rules:
  - 0xE0: set ext. 0xF0: set brk. Neither changes out.
  - Other byte: look up code = map(ext, byte), then clear ext and brk.
  - Unmapped code: no change to out.
  - Mapped code with brk=0 (make):
    - If code != out: out<=code and key_valid=1.
    - If code == out (typematic repeat): no pulse.
  - Mapped code with brk=1 (break): if code == out, out<=0. A break of a different key is ignored.
- Map, ext=0:
  - Letters A-Z -> 65..90: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
  - Digits 0-9 -> 48..57: 45,16,1E,26,25,2E,36,3D,3E,46.
  - 29 -> 32 (space). 5A -> 128 (enter). 66 -> 129 (backspace). 76 -> 140 (esc).
- Map, ext=1: 6B -> 130 (left), 75 -> 131 (up), 74 -> 132 (right), 72 -> 133 (down). All other extended codes are unmapped.
- Pulses: key_valid and frame_err are high for exactly one cycle and never high together.

Test Plan:
- Frame 0x1C, good parity -> out=0x0041 two clocks after the stop edge, key_valid high 1 cycle. Frames F0,1C -> out=0x0000, no key_valid.
- Frame 0x1C, then 0x32 without a break -> out=0x0041, then 0x0042, with two key_valid pulses. Then F0,1C -> out stays 0x0042. Then F0,32 -> out=0.
- Frames E0,75 -> out=0x0083. A repeated E0,75 -> no second key_valid. Then E0,F0,75 -> out=0. A bare 0x75 (not extended) -> unmapped, out unchanged.
- Frame 0x1C with a flipped parity bit -> frame_err pulse, out unchanged. Stop bit forced 0 -> frame_err pulse. A following good 0x29 decodes normally -> out=0x0020.
- Stop ps2_clk after 5 bits for TIMEOUT+10 cycles -> FSM back in IDLE, no frame_err. The next full 0x5A frame -> out=0x0080.
- Assert reset for 1 cycle mid-frame while out=0x0041 -> out=0 the next cycle. The rest of the interrupted frame is ignored or re-synced on its next start bit. A fresh 0x66 -> out=0x0081.

Source files
------------

// File: rtl/ps2_keyboard.sv
// PS/2 set-2 receiver that turns make/break scan codes into a held Hack key code.
// Latency: out/key_valid register 2 clocks after the stop-bit detect cycle; no backpressure (free-running input).
module ps2_keyboard #(
  parameter int TIMEOUT = 5000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] out,
  output logic        key_valid,
  output logic        frame_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RECV   = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DECODE = 2'd3;

  logic          r_clk_s1, r_clk_s2, r_clk_prev;
  logic          r_dat_s1, r_dat_s2;
  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [10:0]   r_shift;
  logic [TW-1:0] r_tmo;
  logic          r_ext, r_brk;
  logic [15:0]   r_out;
  logic          r_key_valid, r_frame_err;

  logic          w_fall;
  logic          w_good;
  logic [7:0]    w_byte;
  logic [15:0]   w_code;

  function automatic logic [15:0] f_map(input logic ext, input logic [7:0] b);
    logic [15:0] code;
    code = 16'd0;
    case ({ext, b})
      9'h01C: code = 16'd65;  9'h032: code = 16'd66;  9'h021: code = 16'd67;
      9'h023: code = 16'd68;  9'h024: code = 16'd69;  9'h02B: code = 16'd70;
      9'h034: code = 16'd71;  9'h033: code = 16'd72;  9'h043: code = 16'd73;
      9'h03B: code = 16'd74;  9'h042: code = 16'd75;  9'h04B: code = 16'd76;
      9'h03A: code = 16'd77;  9'h031: code = 16'd78;  9'h044: code = 16'd79;
      9'h04D: code = 16'd80;  9'h015: code = 16'd81;  9'h02D: code = 16'd82;
      9'h01B: code = 16'd83;  9'h02C: code = 16'd84;  9'h03C: code = 16'd85;
      9'h02A: code = 16'd86;  9'h01D: code = 16'd87;  9'h022: code = 16'd88;
      9'h035: code = 16'd89;  9'h01A: code = 16'd90;
      9'h045: code = 16'd48;  9'h016: code = 16'd49;  9'h01E: code = 16'd50;
      9'h026: code = 16'd51;  9'h025: code = 16'd52;  9'h02E: code = 16'd53;
      9'h036: code = 16'd54;  9'h03D: code = 16'd55;  9'h03E: code = 16'd56;
      9'h046: code = 16'd57;
      9'h029: code = 16'd32;  9'h05A: code = 16'd128; 9'h066: code = 16'd129;
      9'h076: code = 16'd140;
      9'h16B: code = 16'd130; 9'h175: code = 16'd131; 9'h174: code = 16'd132;
      9'h172: code = 16'd133;
      default: code = 16'd0;
    endcase
    return code;
  endfunction

  // Frame layout after 11 shifts: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign w_fall = r_clk_prev & ~r_clk_s2;
  assign w_byte = r_shift[8:1];
  assign w_good = (^r_shift[9:1]) & r_shift[10];
  assign w_code = f_map(r_ext, w_byte);

  assign out       = r_out;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_clk_prev  <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= 11'd0;
      r_tmo       <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_out       <= 16'd0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_clk_prev  <= r_clk_s2;
      r_dat_s1    <= ps2_data;
      r_dat_s2    <= r_dat_s1;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          r_tmo <= '0;
          if (w_fall && !r_dat_s2) begin
            r_shift <= {r_dat_s2, r_shift[10:1]};
            r_cnt   <= 4'd1;
            r_state <= S_RECV;
          end
        end
        S_RECV: begin
          if (w_fall) begin
            r_shift <= {r_dat_s2, r_shift[10:1]};
            r_cnt   <= r_cnt + 4'd1;
            r_tmo   <= '0;
            if (r_cnt == 4'd10) r_state <= S_CHECK;
          end else if (r_tmo == TW'(TIMEOUT)) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_CHECK: begin
          if (w_good) begin
            r_state <= S_DECODE;
          end else begin
            r_frame_err <= 1'b1;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          if (w_byte == 8'hE0) begin
            r_ext <= 1'b1;
          end else if (w_byte == 8'hF0) begin
            r_brk <= 1'b1;
          end else begin
            r_ext <= 1'b0;
            r_brk <= 1'b0;
            // Repeats of the held key and breaks of other keys leave out alone.
            if (w_code != 16'd0) begin
              if (!r_brk) begin
                if (w_code != r_out) begin
                  r_out       <= w_code;
                  r_key_valid <= 1'b1;
                end
              end else if (w_code == r_out) begin
                r_out <= 16'd0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Scoreboarded bench: stimulus queues expected output events, a negedge monitor checks them.
module tb_ps2_keyboard;

  localparam int TMO  = 5000;
  localparam int HALF = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [15:0] out;
  logic        key_valid;
  logic        frame_err;

  ps2_keyboard #(.TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out(out), .key_valid(key_valid), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        kv;
    logic        fe;
    logic [15:0] val;
    int          dly;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ref_cyc = 0;
  bit          mon_en = 1'b0;
  logic [15:0] prev_out = 16'd0;

  always @(posedge clock) cyc <= cyc + 1;

  // Any cycle with a pulse or an out change is an event that must match the queue head.
  always @(negedge clock) begin
    if (mon_en) begin
      if (key_valid || frame_err || out != prev_out) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got kv=%0b fe=%0b out=%h at cyc %0d, required no event",
                   key_valid, frame_err, out, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (key_valid !== e.kv || frame_err !== e.fe || out !== e.val || (cyc - ref_cyc) != e.dly) begin
            n_err++;
            $display("FAIL event: got kv=%0b fe=%0b out=%h dly=%0d, required kv=%0b fe=%0b out=%h dly=%0d",
                     key_valid, frame_err, out, cyc - ref_cyc, e.kv, e.fe, e.val, e.dly);
          end
        end
      end
      prev_out = out;
    end
  end

  task automatic expect_ev(input logic kv, input logic fe, input logic [15:0] val, input int dly);
    exp_t e;
    e.kv = kv; e.fe = fe; e.val = val; e.dly = dly;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Sends the first nbits of an 11-bit frame; the stop-bit falling edge sets ref_cyc.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit, input int nbits);
    logic [10:0] bits;
    bits = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clock);
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) ref_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    @(negedge clock);
    ps2_data = 1'b1;
    wait_cyc(12);
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  initial begin
    wait_cyc(3);
    chk("reset_out", out, 16'h0000);
    chk("reset_key_valid", {15'd0, key_valid}, 16'd0);
    chk("reset_frame_err", {15'd0, frame_err}, 16'd0);
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(4);
    chk("idle_out", out, 16'h0000);
    prev_out = out;
    mon_en = 1'b1;

    // Make then break of A.
    expect_ev(1'b1, 1'b0, 16'h0041, 5); good(8'h1C);
    good(8'hF0);
    expect_ev(1'b0, 1'b0, 16'h0000, 5); good(8'h1C);

    // Rollover A -> B, stale break of A ignored, break of B clears.
    expect_ev(1'b1, 1'b0, 16'h0041, 5); good(8'h1C);
    expect_ev(1'b1, 1'b0, 16'h0042, 5); good(8'h32);
    good(8'hF0); good(8'h1C);
    good(8'hF0);
    expect_ev(1'b0, 1'b0, 16'h0000, 5); good(8'h32);

    // Extended up arrow, typematic repeat, extended break, bare 0x75 unmapped.
    good(8'hE0);
    expect_ev(1'b1, 1'b0, 16'h0083, 5); good(8'h75);
    good(8'hE0); good(8'h75);
    good(8'hE0); good(8'hF0);
    expect_ev(1'b0, 1'b0, 16'h0000, 5); good(8'h75);
    good(8'h75);

    // Parity error, stop-bit error, then a clean space.
    expect_ev(1'b0, 1'b1, 16'h0000, 4); send_frame(8'h1C, 1'b1, 1'b1, 11);
    expect_ev(1'b0, 1'b1, 16'h0000, 4); send_frame(8'h1C, 1'b0, 1'b0, 11);
    expect_ev(1'b1, 1'b0, 16'h0020, 5); good(8'h29);

    // Abandoned frame times out silently; next enter decodes.
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    wait_cyc(TMO + 10);
    expect_ev(1'b1, 1'b0, 16'h0080, 5); good(8'h5A);

    // Reset mid-frame while A is held, then backspace.
    expect_ev(1'b1, 1'b0, 16'h0041, 5); good(8'h1C);
    send_frame(8'h66, 1'b0, 1'b1, 5);
    expect_ev(1'b0, 1'b0, 16'h0000, 1);
    @(negedge clock);
    ref_cyc = cyc;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("reset_mid_frame_out", out, 16'h0000);
    wait_cyc(5);
    expect_ev(1'b1, 1'b0, 16'h0081, 5); good(8'h66);

    wait_cyc(20);
    chk("events_outstanding", 16'(q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
